// File: rtl/inst_align_buffer_pkg.sv
// Shared definitions for the instruction align buffer and decode:
// parcel width, length encodings and the parcel-count helper.
package inst_align_buffer_pkg;

  localparam int PARCEL_W = 16;

  typedef enum logic [1:0] {
    INST_LEN_NONE = 2'b00,
    INST_LEN_16   = 2'b01,
    INST_LEN_32   = 2'b10,
    INST_LEN_64   = 2'b11
  } inst_len_e;

  // Number of parcels an instruction occupies, from its first parcel.
  function automatic logic [2:0] inst_parcels(input logic [PARCEL_W-1:0] parcel);
    logic [2:0] n;
    case (parcel[15:14])
      2'b10:   n = 3'd2;
      2'b11:   n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Length encoding presented to decode, from the first parcel.
  function automatic inst_len_e inst_len_enc(input logic [PARCEL_W-1:0] parcel);
    inst_len_e l;
    case (parcel[15:14])
      2'b10:   l = INST_LEN_32;
      2'b11:   l = INST_LEN_64;
      default: l = INST_LEN_16;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/inst_align_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the instruction align buffer.
// master: the environment (fetch + decode); slave: the buffer itself.
interface inst_align_buffer_if;

  logic [63:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [63:0] inst_word;
  logic [1:0]  inst_len;
  logic        inst_valid;
  logic        inst_take;

  modport master (
    output fetch_data, fetch_valid, inst_take,
    input  fetch_ready, inst_word, inst_len, inst_valid
  );

  modport slave (
    input  fetch_data, fetch_valid, inst_take,
    output fetch_ready, inst_word, inst_len, inst_valid
  );

endinterface

// File: rtl/inst_align_buffer_window_extract.sv
// Reads the four parcels starting at head (wrapping around the parcel ring),
// decides the head instruction length and presents it left-aligned with the
// unused parcels zeroed. Nothing is shown until every parcel is present.
module inst_window_extract
  import inst_align_buffer_pkg::*;
#(
  parameter int DEPTH_PARCELS = 8,
  parameter int AW            = $clog2(DEPTH_PARCELS)
) (
  input  logic [DEPTH_PARCELS-1:0][PARCEL_W-1:0] mem,
  input  logic [AW-1:0]                          head,
  input  logic [AW:0]                            count,
  output logic [63:0]                            inst_word,
  output logic [1:0]                             inst_len,
  output logic                                   inst_valid,
  output logic [2:0]                             needed
);

  logic [PARCEL_W-1:0] par [4];
  logic [AW-1:0]       idx;

  // Gather the window; pointer addition wraps because depth is a power of two.
  always_comb begin
    idx = head;
    for (int k = 0; k < 4; k++) begin
      idx    = head + AW'(k);
      par[k] = mem[idx];
    end
  end

  // Length decode, completeness test and masking of parcels past the length.
  always_comb begin
    needed     = inst_parcels(par[0]);
    inst_valid = (count >= (AW+1)'(needed));
    if (inst_valid) begin
      inst_len = inst_len_enc(par[0]);
      case (needed)
        3'd1:    inst_word = {par[0], 48'h0};
        3'd2:    inst_word = {par[0], par[1], 32'h0};
        3'd4:    inst_word = {par[0], par[1], par[2], par[3]};
        default: inst_word = 64'h0;
      endcase
    end else begin
      inst_len  = INST_LEN_NONE;
      inst_word = 64'h0;
    end
  end

endmodule

// File: rtl/inst_align_buffer.sv
// Parcel-granular instruction queue between fetch and decode. Fetch pushes
// 64-bit words (four parcels, [63:48] first); decode pops whole instructions
// of 1, 2 or 4 parcels, including ones that straddle fetch words or the ring wrap.
module inst_align_buffer
  import inst_align_buffer_pkg::*;
#(
  parameter int DEPTH_PARCELS = 8,
  localparam int AW           = $clog2(DEPTH_PARCELS)
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_align_buffer_if.slave bus,
  input  logic               flush,
  output logic [AW:0]        occupancy
);

  localparam logic [AW:0] READY_MAX = (AW+1)'(DEPTH_PARCELS - 4);
  localparam logic [AW:0] WORD_PARCELS = (AW+1)'(4);

  logic [DEPTH_PARCELS-1:0][PARCEL_W-1:0] mem;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic [AW-1:0] wr_idx [4];
  logic [2:0]    needed;
  logic          fetch_ready;
  logic          inst_valid;
  logic          push;
  logic          pop;
  logic [AW:0]   add_n;
  logic [AW:0]   sub_n;

  inst_window_extract #(
    .DEPTH_PARCELS(DEPTH_PARCELS),
    .AW           (AW)
  ) u_window (
    .mem       (mem),
    .head      (head),
    .count     (count),
    .inst_word (bus.inst_word),
    .inst_len  (bus.inst_len),
    .inst_valid(inst_valid),
    .needed    (needed)
  );

  // Handshake qualification; ready uses the pre-pop count so a pop gives no same-cycle credit.
  always_comb begin
    fetch_ready = (count <= READY_MAX);
    push        = bus.fetch_valid & fetch_ready;
    pop         = bus.inst_take & inst_valid;
    if (push) begin
      add_n = WORD_PARCELS;
    end else begin
      add_n = '0;
    end
    if (pop) begin
      sub_n = (AW+1)'(needed);
    end else begin
      sub_n = '0;
    end
    for (int k = 0; k < 4; k++) begin
      wr_idx[k] = tail + AW'(k);
    end
  end

  assign bus.fetch_ready = fetch_ready;
  assign bus.inst_valid  = inst_valid;
  assign occupancy       = count;

  // Head/tail/count update; flush wins over any concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + AW'(needed);
      end
      if (push) begin
        tail <= tail + AW'(4);
      end
      count <= count + add_n - sub_n;
    end
  end

  // Parcel storage: a pushed word lands at tail in address order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (push && !flush) begin
      for (int k = 0; k < 4; k++) begin
        mem[wr_idx[k]] <= bus.fetch_data[63-16*k -: 16];
      end
    end
  end

endmodule

// File: tb/tb_inst_align_buffer.sv
// Self-checking bench for inst_align_buffer: directed scenarios followed by a
// long random stream, all compared against a parcel-queue reference model.
module tb_inst_align_buffer;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] occupancy;

  inst_align_buffer_if bus();

  inst_align_buffer #(.DEPTH_PARCELS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .flush    (flush),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] q[$];

  function automatic int need_of(input logic [15:0] p);
    if (p[15] == 1'b0) return 1;
    if (p[14] == 1'b0) return 2;
    return 4;
  endfunction

  function automatic logic m_valid();
    if (q.size() == 0) return 1'b0;
    return (q.size() >= need_of(q[0]));
  endfunction

  function automatic logic [63:0] m_word();
    logic [63:0] w;
    w = 64'h0;
    if (m_valid()) begin
      for (int i = 0; i < need_of(q[0]); i++) w[63-16*i -: 16] = q[i];
    end
    return w;
  endfunction

  function automatic logic [1:0] m_len();
    if (!m_valid()) return 2'b00;
    case (need_of(q[0]))
      1:       return 2'b01;
      2:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_valid"}, {63'h0, bus.inst_valid}, {63'h0, m_valid()});
    chk({tag, "_len"},   {62'h0, bus.inst_len},   {62'h0, m_len()});
    chk({tag, "_word"},  bus.inst_word,           m_word());
    chk({tag, "_ready"}, {63'h0, bus.fetch_ready}, {63'h0, (q.size() <= 4)});
    chk({tag, "_occ"},   {60'h0, occupancy},      64'(q.size()));
  endtask

  // One clock: apply inputs, check model vs DUT, advance both on the edge.
  task automatic step(input logic fv, input logic [63:0] fd, input logic tk, input logic fl);
    logic v;
    logic rdy;
    int   nd;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.inst_take   = tk;
    flush           = fl;
    check_model("step");
    v   = m_valid();
    rdy = (q.size() <= 4);
    nd  = (q.size() > 0) ? need_of(q[0]) : 0;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (tk && v) begin
        for (int i = 0; i < nd; i++) void'(q.pop_front());
      end
      if (fv && rdy) begin
        for (int i = 0; i < 4; i++) q.push_back(fd[63-16*i -: 16]);
      end
    end
    #1;
    bus.fetch_valid = 1'b0;
    bus.inst_take   = 1'b0;
    flush           = 1'b0;
  endtask

  function automatic logic [15:0] rand_parcel();
    logic [15:0] p;
    p = 16'($urandom);
    return p;
  endfunction

  initial begin
    logic [63:0] rw;
    rst_n           = 1'b0;
    flush           = 1'b0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 64'h0;
    bus.inst_take   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset_word", bus.inst_word, 64'h0);
    chk("reset_ready", {63'h0, bus.fetch_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single 16-bit instruction visible right after the push edge.
    step(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    chk("d1_valid", {63'h0, bus.inst_valid}, 64'h1);
    chk("d1_len", {62'h0, bus.inst_len}, 64'h1);
    chk("d1_word", bus.inst_word, 64'h1111_0000_0000_0000);

    // Mixed 32b then 64b straddling two fetch words.
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 64'h8001_0002_C003_0004, 1'b0, 1'b0);
    step(1'b1, 64'h0005_0006_0007_0008, 1'b0, 1'b0);
    chk("d2_word32", bus.inst_word, 64'h8001_0002_0000_0000);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("d2_word64", bus.inst_word, 64'hC003_0004_0005_0006);
    chk("d2_len64", {62'h0, bus.inst_len}, 64'h3);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Fill with fetch_valid held, then drain 16b instructions.
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 64'h0001_0002_0003_0004, 1'b0, 1'b0);
    step(1'b1, 64'h0001_0002_0003_0004, 1'b0, 1'b0);
    chk("d3_full_ready", {63'h0, bus.fetch_ready}, 64'h0);
    chk("d3_full_occ", {60'h0, occupancy}, 64'd8);
    for (int i = 0; i < 5; i++) step(1'b1, 64'h0001_0002_0003_0004, 1'b1, 1'b0);

    // 64b instruction incomplete until the next word arrives.
    step(1'b0, 64'h0, 1'b0, 1'b1);
    step(1'b1, 64'h0001_0002_0003_C004, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
    chk("d4_partial_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("d4_partial_word", bus.inst_word, 64'h0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 64'h0005_0006_0007_0008, 1'b0, 1'b0);
    chk("d4_straddle_word", bus.inst_word, 64'hC004_0005_0006_0007);

    // Flush beats concurrent push and pop.
    step(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
    chk("d5_occ", {60'h0, occupancy}, 64'd0);
    chk("d5_valid", {63'h0, bus.inst_valid}, 64'h0);
    chk("d5_ready", {63'h0, bus.fetch_ready}, 64'h1);

    // Random mixed-length stream with stalls, flushes and one async reset.
    for (int c = 0; c < 800; c++) begin
      rw = {rand_parcel(), rand_parcel(), rand_parcel(), rand_parcel()};
      if (c == 400) begin
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        check_model("midreset");
        #1;
        rst_n = 1'b1;
        #1;
      end
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, rw,
           ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end
    check_model("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
